// File: rtl/pmem_pkg.sv
// Shared types and constants for the cache-line physical-memory responder.
package pmem_pkg;

  localparam int OFFSET_W    = 5;
  localparam int LINE_BYTES  = 32;
  localparam int PMEM_LINE_W = LINE_BYTES * 8;

  typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage with per-line valid bits: synchronous write, registered read.
// Lines that were never written since reset read back as all zeros.
module pmem_line_array #(
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [LINE_W-1:0] rdata
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  // Data storage is deliberately not reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        valid[widx] <= 1'b1;
      end
      if (re) begin
        rdata <= valid[ridx] ? mem[ridx] : '0;
      end
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Responder for the cache-line pmem interface: fixed-latency line reads and
// writes from an internal array, plus a sticky initiator protocol checker.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int IDX_W   = 4,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              protocol_err,
  output logic              busy,
  output pmem_state_t       dbg_state
);

  // Handshake: the initiator raises pmem_read or pmem_write with a stable
  // address/wdata and holds all of them until it sees the one-cycle pmem_resp;
  // any change while BUSY/RESP is a violation, the captured request still wins.

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  pmem_state_t       state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_write;
  logic [LINE_W-1:0] cap_wdata;

  logic              req;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              rd_en;
  logic              violation;

  assign req     = pmem_read | pmem_write;
  assign req_idx = pmem_address[OFFSET_W+IDX_W-1:OFFSET_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_idx      <= '0;
      cap_write    <= 1'b0;
      cap_wdata    <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_idx   <= req_idx;
        cap_write <= pmem_write;
        cap_wdata <= pmem_wdata;
      end
      if (violation) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Counter reaches zero as the FSM enters RESP, so RESP is the LATENCY-th
  // cycle after acceptance; with LATENCY=1 there is no BUSY cycle at all.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          cnt_n  = LAT_M1;
          if (LATENCY == 1) begin
            state_n = RESP;
            rd_en   = ~pmem_write;
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_n = RESP;
          rd_en   = ~cap_write;
        end
      end
      RESP:    state_n = TURN;
      TURN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    violation = accept & pmem_read & pmem_write;
    if ((state == BUSY) || (state == RESP)) begin
      if (!req || (req_idx != cap_idx) || (pmem_write != cap_write) ||
          (cap_write && (pmem_wdata != cap_wdata))) begin
        violation = 1'b1;
      end
    end
  end

  pmem_line_array #(
    .IDX_W  (IDX_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    ((state == RESP) && cap_write),
    .widx  (cap_idx),
    .wdata (cap_wdata),
    .re    (rd_en),
    .ridx  ((state == IDLE) ? req_idx : cap_idx),
    .rdata (pmem_rdata)
  );

  assign pmem_resp = (state == RESP);
  assign busy      = (state == BUSY) || (state == RESP);
  assign dbg_state = state;

endmodule
